// File: rtl/tetron_collision_checker_if.sv
// Bus bundle between the game-control FSM / playfield RAM (master side)
// and the tetron collision checker (slave side).
interface tetron_collision_checker_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [4:0]        origin_row;
    logic [4:0]        origin_col;
    logic [4:0]        blk1_voffset;
    logic [4:0]        blk2_voffset;
    logic [4:0]        blk3_voffset;
    logic [4:0]        blk4_voffset;
    logic [4:0]        blk1_hoffset;
    logic [4:0]        blk2_hoffset;
    logic [4:0]        blk3_hoffset;
    logic [4:0]        blk4_hoffset;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              busy;
    logic              done;
    logic              collision;

    modport master (
        output start, origin_row, origin_col,
        output blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset,
        output blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset,
        output rd_data,
        input  rd_en, rd_addr, busy, done, collision
    );

    modport slave (
        input  start, origin_row, origin_col,
        input  blk1_voffset, blk2_voffset, blk3_voffset, blk4_voffset,
        input  blk1_hoffset, blk2_hoffset, blk3_hoffset, blk4_hoffset,
        input  rd_data,
        output rd_en, rd_addr, busy, done, collision
    );
endinterface

// File: rtl/tetron_collision_checker.sv
// Tetron collision checker: walks the four blocks of a placed piece, bounds
// checks each target cell and reads its occupancy bit, stopping at the first
// collision.
// Optional feature macro: TETRON_COLL_ALLOW_ABOVE_EN -- blocks above the top
// row (row < 0, column in range) count as free so pieces can spawn partly
// above the field.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; result of the last check held
// S_CHECK | bounds check of block idx, issue playfield read if in range
// S_EVAL  | inspect occupancy bit returned for block idx
// S_DONE  | one-cycle done pulse, then back to idle
module tetron_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ADDR_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    tetron_collision_checker_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic signed [6:0] BOARD_H_S = 7'(BOARD_H);
    localparam logic signed [6:0] BOARD_W_S = 7'(BOARD_W);

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [4:0]       orow_q;
    logic [4:0]       ocol_q;
    logic [3:0][4:0]  voff_q;
    logic [3:0][4:0]  hoff_q;
    logic             coll_q;
    logic             busy_q;
    logic             done_q;

    logic [4:0]        voff_sel;
    logic [4:0]        hoff_sel;
    logic signed [6:0] row_c;
    logic signed [6:0] col_c;
    logic              row_oob;
    logic              col_oob;
    logic              in_bounds;
    logic              above_ok;
    logic [ADDR_W-1:0] addr_c;

    // Target cell of the current block; 7-bit signed covers -16..46.
    always_comb begin
        voff_sel  = voff_q[idx_q];
        hoff_sel  = hoff_q[idx_q];
        row_c     = $signed({2'b00, orow_q}) + $signed({{2{voff_sel[4]}}, voff_sel});
        col_c     = $signed({2'b00, ocol_q}) + $signed({{2{hoff_sel[4]}}, hoff_sel});
        row_oob   = row_c[6] || (row_c >= BOARD_H_S);
        col_oob   = col_c[6] || (col_c >= BOARD_W_S);
        in_bounds = !row_oob && !col_oob;
`ifdef TETRON_COLL_ALLOW_ABOVE_EN
        above_ok  = row_c[6] && !col_oob;
`else
        above_ok  = 1'b0;
`endif
        addr_c    = ADDR_W'(row_c[5:0]) * ADDR_W'(BOARD_W) + ADDR_W'(col_c[5:0]);
    end

    // Read strobe only for an in-range block while in CHECK.
    always_comb begin
        bus.rd_en   = (state_q == S_CHECK) && in_bounds;
        bus.rd_addr = bus.rd_en ? addr_c : '0;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.collision = coll_q;

    // Main FSM with registered busy/done/collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            orow_q  <= '0;
            ocol_q  <= '0;
            voff_q  <= '0;
            hoff_q  <= '0;
            coll_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        orow_q  <= bus.origin_row;
                        ocol_q  <= bus.origin_col;
                        voff_q  <= {bus.blk4_voffset, bus.blk3_voffset,
                                    bus.blk2_voffset, bus.blk1_voffset};
                        hoff_q  <= {bus.blk4_hoffset, bus.blk3_hoffset,
                                    bus.blk2_hoffset, bus.blk1_hoffset};
                        idx_q   <= 2'd0;
                        coll_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (in_bounds) begin
                        state_q <= S_EVAL;
                    end else if (above_ok) begin
                        // Block above the field: skip it without a read.
                        if (idx_q == 2'd3) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else begin
                        coll_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_EVAL: begin
                    if (bus.rd_data) begin
                        coll_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (idx_q == 2'd3) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= S_CHECK;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tetron_collision_checker.sv
// Scoreboard bench for tetron_collision_checker: each issued check pushes its
// expected result, latency and read-address list; a monitor pops on done.
module tb_tetron_collision_checker;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    tetron_collision_checker_if #(.ADDR_W(8)) bus ();

    tetron_collision_checker #(
        .BOARD_W(10),
        .BOARD_H(20),
        .ADDR_W (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Playfield RAM model, one-cycle read latency.
    logic mem [256];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    typedef struct packed {
        logic            coll;
        logic [31:0]     lat;
        logic [2:0]      nrd;
        logic [3:0][7:0] a;
        logic [31:0]     t0;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: collect read addresses, compare against scoreboard on done.
    int         nobs = 0;
    logic [7:0] obs [8];
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst) begin
            nobs = 0;
        end else begin
            if (bus.rd_en) begin
                if (nobs < 8) obs[nobs] = bus.rd_addr;
                nobs = nobs + 1;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with no check outstanding, required 0", cyc);
                end else begin
                    bit ok;
                    mon_e = sb.pop_front();
                    chk("collision", 32'(bus.collision), 32'(mon_e.coll));
                    chk("latency", 32'(cyc) - mon_e.t0, mon_e.lat);
                    ok = (nobs == int'(mon_e.nrd));
                    for (int i = 0; i < 4; i++)
                        if (i < int'(mon_e.nrd) && obs[i] != mon_e.a[i]) ok = 0;
                    n_chk++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL reads: got %0d reads [%0d %0d %0d %0d], required %0d reads [%0d %0d %0d %0d]",
                                 nobs, obs[0], obs[1], obs[2], obs[3], mon_e.nrd,
                                 mon_e.a[0], mon_e.a[1], mon_e.a[2], mon_e.a[3]);
                    end
                end
                nobs = 0;
                for (int i = 0; i < 8; i++) obs[i] = 8'hFF;
            end
        end
    end

    task automatic run_check(input logic [4:0] r, input logic [4:0] c,
                             input logic [3:0][4:0] vo, input logic [3:0][4:0] ho,
                             input logic ec, input int lat, input int nrd,
                             input logic [3:0][7:0] ea, input bit poke);
        exp_t e;
        bit   seen;
        @(negedge clk);
        bus.origin_row   = r;
        bus.origin_col   = c;
        bus.blk1_voffset = vo[0];
        bus.blk2_voffset = vo[1];
        bus.blk3_voffset = vo[2];
        bus.blk4_voffset = vo[3];
        bus.blk1_hoffset = ho[0];
        bus.blk2_hoffset = ho[1];
        bus.blk3_hoffset = ho[2];
        bus.blk4_hoffset = ho[3];
        bus.start        = 1'b1;
        e.coll = ec;
        e.lat  = 32'(lat);
        e.nrd  = 3'(nrd);
        e.a    = ea;
        e.t0   = 32'(cyc + 1);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        #1 chk("busy_rise", 32'(bus.busy), 32'd1);
        if (poke) begin
            @(negedge clk);
            bus.origin_row = 5'd0;
            bus.origin_col = 5'd0;
            bus.start      = 1'b1;
            @(negedge clk);
            bus.start      = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: no done within 40 cycles, required done");
            sb.delete();
        end else begin
            @(negedge clk);
            #1;
            chk("busy_fall", 32'(bus.busy), 32'd0);
            chk("done_one_cycle", 32'(bus.done), 32'd0);
            chk("collision_hold", 32'(bus.collision), 32'(ec));
        end
    endtask

    logic [3:0][4:0] v_std, h_std, zero5, v_down, h_right;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;
        bus.rd_data      = 1'b0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.origin_row   = '0;
        bus.origin_col   = '0;
        bus.blk1_voffset = '0;
        bus.blk2_voffset = '0;
        bus.blk3_voffset = '0;
        bus.blk4_voffset = '0;
        bus.blk1_hoffset = '0;
        bus.blk2_hoffset = '0;
        bus.blk3_hoffset = '0;
        bus.blk4_hoffset = '0;

        // offsets (0,0),(-1,0),(0,-1),(1,-1), index 0 = blk1
        v_std   = {5'd1, 5'd0, 5'h1F, 5'd0};
        h_std   = {5'h1F, 5'h1F, 5'd0, 5'd0};
        zero5   = '0;
        v_down  = {5'd0, 5'd0, 5'd0, 5'd1};
        h_right = {5'd0, 5'd0, 5'd1, 5'd0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_collision", 32'(bus.collision), 32'd0);
        chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        rst = 1'b0;

        // Clean pass on empty board.
        run_check(5'd5, 5'd4, v_std, h_std, 1'b0, 8, 4, {8'd63, 8'd53, 8'd44, 8'd54}, 0);
        // Cell 53 filled: stop at block 3.
        mem[53] = 1'b1;
        run_check(5'd5, 5'd4, v_std, h_std, 1'b1, 6, 3, {8'd0, 8'd53, 8'd44, 8'd54}, 0);
        mem[53] = 1'b0;
        // Bottom row origin, block 3 left of column 0.
        run_check(5'd19, 5'd0, v_std, h_std, 1'b1, 5, 2, {8'd0, 8'd0, 8'd180, 8'd190}, 0);
        // Block 2 above the top row.
`ifdef TETRON_COLL_ALLOW_ABOVE_EN
        run_check(5'd0, 5'd4, v_std, h_std, 1'b0, 7, 3, {8'd0, 8'd13, 8'd3, 8'd4}, 0);
`else
        run_check(5'd0, 5'd4, v_std, h_std, 1'b1, 3, 1, {8'd0, 8'd0, 8'd0, 8'd4}, 0);
`endif
        // First block filled.
        mem[54] = 1'b1;
        run_check(5'd5, 5'd4, v_std, h_std, 1'b1, 2, 1, {8'd0, 8'd0, 8'd0, 8'd54}, 0);
        mem[54] = 1'b0;
        // First block one row below the field.
        run_check(5'd19, 5'd5, v_down, zero5, 1'b1, 1, 0, '0, 0);
        // Column 9 legal, column 10 out of bounds.
        run_check(5'd0, 5'd9, zero5, h_right, 1'b1, 3, 1, {8'd0, 8'd0, 8'd0, 8'd9}, 0);
        // Bottom-right corner cell, all four blocks on it.
        run_check(5'd19, 5'd9, zero5, zero5, 1'b0, 8, 4, {8'd199, 8'd199, 8'd199, 8'd199}, 0);
        // start pulsed while busy with a different origin: ignored.
        run_check(5'd5, 5'd4, v_std, h_std, 1'b0, 8, 4, {8'd63, 8'd53, 8'd44, 8'd54}, 1);
        repeat (4) @(negedge clk);

        // Reset while in EVAL with a filled cell pending.
        mem[54] = 1'b1;
        @(negedge clk);
        bus.origin_row   = 5'd5;
        bus.origin_col   = 5'd4;
        bus.blk1_voffset = 5'd0;
        bus.blk1_hoffset = 5'd0;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1 chk("mid_rd_en", 32'(bus.rd_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_collision", 32'(bus.collision), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("abort_no_done", 32'(bus.done), 32'd0);
        mem[54] = 1'b0;

        // Normal operation after the abort.
        run_check(5'd5, 5'd4, v_std, h_std, 1'b0, 8, 4, {8'd63, 8'd53, 8'd44, 8'd54}, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
